lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the execute/memory path.
- Takes the ALU-computed effective address plus store data and runs one data-memory transaction over a req/gnt/rvalid bus.
- Returns a sign- or zero-extended load result, or a completion strobe for stores.
- Flags misaligned accesses, illegal sizes and (optionally) bus timeouts; the core stalls on busy.

Parameters:
WIDTH, 32, data/address width; only 32 supported (elaboration-time check).
TIMEOUT_CYCLES, 64, cycles to wait for mem_gnt or mem_rvalid before timeout (used only with LSU_TIMEOUT_EN).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  core requests an access.
req_ready  output  1  LSU idle, request can be accepted.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  input  WIDTH  effective address (ALU result).
req_wdata  input  WIDTH  store data (rs2).
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
resp_err  output  2  00 ok, 01 misaligned, 10 illegal size, 11 timeout.
busy  output  1  state != IDLE.
mem_req  output  1  memory request.
mem_we  output  1  memory write enable.
mem_addr  output  WIDTH  word-aligned address ({req_addr[31:2],2'b00}).
mem_be  output  4  byte enables.
mem_wdata  output  WIDTH  lane-replicated store data.
mem_gnt  input  1  request accepted by memory.
mem_rvalid  input  1  read data valid.
mem_rdata  input  WIDTH  read word.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_rdata, resp_err, busy all 0; req_ready=1.
- req_ready = (state==IDLE). Acceptance = req_valid && req_ready. On acceptance, latch we, funct3, addr[1:0] and wdata.
- Checks at acceptance, in priority order:
  - Illegal size (funct3 011/110/111, or a store with funct3[2]=1): state ERR, resp_err=10.
  - Misaligned (H/HU with addr[0]!=0, W with addr[1:0]!=0): state ERR, resp_err=01.
  - Either error: no mem_req is ever issued.
  - Otherwise: state REQ.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
  - IDLE -> REQ/ERR on acceptance.
  - REQ: mem_req held high with stable mem_* until mem_gnt.
    - Store + gnt -> RESP.
    - Load + gnt + rvalid in the same cycle -> RESP (capture data).
    - Load + gnt without rvalid -> WAIT.
  - WAIT: mem_req=0; on mem_rvalid capture mem_rdata -> RESP.
  - RESP/ERR: resp_valid=1 for exactly one cycle -> IDLE.
- All outputs are registered.
- Latency, with acceptance at cycle 0:
  - mem_req rises at cycle 1.
  - Gnt at cycle 1 with a store: resp_valid at cycle 2.
  - Rvalid at cycle m for a load: resp_valid at m+1.
  - Error: resp_valid at cycle 1.
  - Back-to-back: next request is accepted the cycle after resp_valid.
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<addr[1:0].
  - SW: mem_be=4'b1111.
- Loads: mem_be set the same way as stores. Select the byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
- Inputs are ignored while busy.
- mem_gnt/mem_rvalid outside REQ/WAIT are ignored.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req drops asynchronously, and no resp_valid is produced for the aborted access.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ/WAIT and increments each cycle there. On reaching TIMEOUT_CYCLES without the awaited gnt/rvalid: deassert mem_req, go to RESP with resp_err=11 and resp_rdata=0. Late gnt/rvalid afterwards is ignored.
- Undefined: no counter; the LSU waits indefinitely and resp_err never equals 11.

Decomposition:
- Package common: lsu_state_t enum (IDLE, REQ, WAIT, RESP, ERR); lsu_err_t enum (ERR_NONE, ERR_MISALIGN, ERR_SIZE, ERR_TIMEOUT); funct3 constants LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101.
- Sub-module lsu_load_align: combinational. Inputs: mem_rdata, addr[1:0], funct3. Output: extended 32-bit result. Instantiated once in lsu.

Test Plan:
- LW addr=0x100, gnt at cycle 1, rvalid at cycle 3 with rdata=0xDEADBEEF -> resp_valid at cycle 4, resp_rdata=0xDEADBEEF, resp_err=00.
- LB addr=0x103, rdata=0x80FF_FF01 -> resp_rdata=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, gnt same cycle as mem_req -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD; resp_valid next cycle.
- LW addr=0x101 -> resp_valid at cycle 1, resp_err=01, mem_req never asserted. Store with funct3=100 -> resp_err=10.
- Reset pulled low while in WAIT -> mem_req/busy=0 immediately, req_ready=1 after release, no resp_valid; a following LW completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_gnt held low -> mem_req drops after 4 cycles, resp_err=11. Without the macro, mem_req stays high indefinitely.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and RV32I size encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_SIZE     = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Byte-enable mask for an access of the given size at byte offset off.
    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LS_B, LS_BU: lane_be = 4'b0001 << off;
            LS_H, LS_HU: lane_be = 4'b0011 << off;
            default:     lane_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory bus signals of the load/store unit.
interface lsu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic [1:0]       resp_err;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            LS_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LS_BU:   result = {24'h000000, byte_sel};
            LS_H:    result = {{16{half_sel[15]}}, half_sel};
            LS_HU:   result = {16'h0000, half_sel};
            default: result = mem_rdata;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// lsu: one data-memory transaction per request over a req/gnt/rvalid bus.
// Define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES for gnt/rvalid.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);
    if (WIDTH != 32) begin : g_width_check
        $error("lsu: only WIDTH=32 is supported");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("lsu: TIMEOUT_CYCLES must be nonzero");
    end

    lsu_state_t       state_q, state_n;
    logic             we_q, we_n;
    logic [2:0]       funct3_q, funct3_n;
    logic [1:0]       off_q, off_n;
    logic             mem_we_n;
    logic [WIDTH-1:0] mem_addr_n, mem_wdata_n, rdata_n, load_data;
    logic [3:0]       mem_be_n;
    lsu_err_t         err_n;
    logic             size_bad, misalign, timeout;

    lsu_load_align u_load_align (
        .mem_rdata (bus.mem_rdata),
        .addr      (off_q),
        .funct3    (funct3_q),
        .result    (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cleared on every entry into REQ or WAIT, counts while staying there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_n == REQ || state_n == WAIT) && state_n == state_q) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        size_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
        misalign = ((bus.req_funct3 == LS_H || bus.req_funct3 == LS_HU) && bus.req_addr[0]) ||
                   ((bus.req_funct3 == LS_W) && (bus.req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_n     = state_q;
        we_n        = we_q;
        funct3_n    = funct3_q;
        off_n       = off_q;
        mem_we_n    = bus.mem_we;
        mem_addr_n  = bus.mem_addr;
        mem_be_n    = bus.mem_be;
        mem_wdata_n = bus.mem_wdata;
        rdata_n     = '0;
        err_n       = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_n     = bus.req_we;
                    funct3_n = bus.req_funct3;
                    off_n    = bus.req_addr[1:0];
                    if (size_bad) begin
                        state_n = ERR;
                        err_n   = ERR_SIZE;
                    end else if (misalign) begin
                        state_n = ERR;
                        err_n   = ERR_MISALIGN;
                    end else begin
                        state_n    = REQ;
                        mem_we_n   = bus.req_we;
                        mem_addr_n = {bus.req_addr[WIDTH-1:2], 2'b00};
                        mem_be_n   = lane_be(bus.req_funct3, bus.req_addr[1:0]);
                        case (bus.req_funct3[1:0])
                            2'b00:   mem_wdata_n = {4{bus.req_wdata[7:0]}};
                            2'b01:   mem_wdata_n = {2{bus.req_wdata[15:0]}};
                            default: mem_wdata_n = bus.req_wdata;
                        endcase
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    if (we_q) begin
                        state_n = RESP;
                    end else if (bus.mem_rvalid) begin
                        state_n = RESP;
                        rdata_n = load_data;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (timeout) begin
                    state_n = RESP;
                    err_n   = ERR_TIMEOUT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_n = RESP;
                    rdata_n = load_data;
                end else if (timeout) begin
                    state_n = RESP;
                    err_n   = ERR_TIMEOUT;
                end
            end
            RESP, ERR: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Every output is registered from the next-state decode so it changes only on clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            we_q           <= 1'b0;
            funct3_q       <= '0;
            off_q          <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= '0;
            bus.busy       <= 1'b0;
            bus.req_ready  <= 1'b1;
        end else begin
            state_q        <= state_n;
            we_q           <= we_n;
            funct3_q       <= funct3_n;
            off_q          <= off_n;
            bus.mem_req    <= (state_n == REQ);
            bus.mem_we     <= mem_we_n;
            bus.mem_addr   <= mem_addr_n;
            bus.mem_be     <= mem_be_n;
            bus.mem_wdata  <= mem_wdata_n;
            bus.resp_valid <= (state_n == RESP) || (state_n == ERR);
            bus.resp_rdata <= rdata_n;
            bus.resp_err   <= err_n;
            bus.busy       <= (state_n != IDLE);
            bus.req_ready  <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stimulus pushes expected responses, a monitor pops and checks them.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    lsu_if #(.WIDTH(32)) bus ();

    lsu #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] rdata, input logic [1:0] err);
        sb.push_back(exp_t'{rdata: rdata, err: err});
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && bus.resp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata %h err %b expected no response",
                         bus.resp_rdata, bus.resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", {30'd0, bus.resp_err}, {30'd0, e.err});
            end
        end
    end

    // Presents one request, returns one cycle after acceptance (cycle 1).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int unsigned n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_ready_wait: got req_ready 0 expected 1 within 50 cycles");
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        step();
        bus.req_valid  = 1'b0;
    endtask

    // Load granted with data in the same cycle as mem_req rises.
    task automatic load_fast(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
        expect_resp(exp, ERR_NONE);
        issue(1'b0, f3, a, 32'h0);
        check({name, "_mem_req"}, {31'd0, bus.mem_req}, 32'd1);
        check({name, "_mem_be"}, {28'd0, bus.mem_be}, {28'd0, be});
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check({name, "_resp_cycle"}, {31'd0, bus.resp_valid}, 32'd1);
        step();
    endtask

    task automatic store_fast(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [31:0] wexp);
        expect_resp(32'h0, ERR_NONE);
        issue(1'b1, f3, a, wd);
        check({name, "_mem_we"}, {31'd0, bus.mem_we}, 32'd1);
        check({name, "_mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        check({name, "_mem_be"}, {28'd0, bus.mem_be}, {28'd0, be});
        check({name, "_mem_wdata"}, bus.mem_wdata, wexp);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check({name, "_resp_cycle"}, {31'd0, bus.resp_valid}, 32'd1);
        check({name, "_ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
        step();
        check({name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic err_txn(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [1:0] err);
        expect_resp(32'h0, err);
        issue(we, f3, a, 32'hFFFF_FFFF);
        check({name, "_resp_cycle"}, {31'd0, bus.resp_valid}, 32'd1);
        check({name, "_no_mem_req1"}, {31'd0, bus.mem_req}, 32'd0);
        step();
        check({name, "_no_mem_req2"}, {31'd0, bus.mem_req}, 32'd0);
        check({name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        reset = 1'b1;
        step();

        // LW with gnt at cycle 1, rvalid at cycle 3; a request while busy is ignored.
        expect_resp(32'hDEAD_BEEF, ERR_NONE);
        issue(1'b0, LS_W, 32'h100, 32'h0);
        check("lw_mem_req", {31'd0, bus.mem_req}, 32'd1);
        check("lw_mem_addr", bus.mem_addr, 32'h100);
        check("lw_mem_be", {28'd0, bus.mem_be}, 32'hF);
        check("lw_busy", {31'd0, bus.busy}, 32'd1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        check("lw_wait_req_low", {31'd0, bus.mem_req}, 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = LS_W;
        bus.req_addr   = 32'h500;
        step();
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.mem_rvalid = 1'b0;
        check("lw_resp_cycle4", {31'd0, bus.resp_valid}, 32'd1);
        step();
        check("lw_ready_after", {31'd0, bus.req_ready}, 32'd1);

        load_fast("lb",  LS_B,  32'h103, 32'h80FF_FF01, 4'b1000, 32'hFFFF_FF80);
        load_fast("lbu", LS_BU, 32'h103, 32'h80FF_FF01, 4'b1000, 32'h0000_0080);
        load_fast("lh",  LS_H,  32'h102, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
        load_fast("lhu", LS_HU, 32'h102, 32'h8001_7FFF, 4'b1100, 32'h0000_8001);
        load_fast("lh0", LS_H,  32'h100, 32'h1234_7FFF, 4'b0011, 32'h0000_7FFF);

        store_fast("sh", LS_H, 32'h202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_fast("sb", LS_B, 32'h101, 32'h0000_0055, 4'b0010, 32'h5555_5555);
        store_fast("sw", LS_W, 32'h204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        err_txn("lw_mis",   1'b0, LS_W,   32'h101, ERR_MISALIGN);
        err_txn("lhu_mis",  1'b0, LS_HU,  32'h103, ERR_MISALIGN);
        err_txn("sbu_size", 1'b1, LS_BU,  32'h100, ERR_SIZE);
        err_txn("f011_pri", 1'b0, 3'b011, 32'h101, ERR_SIZE);

        // Reset in REQ: mem_req must drop without waiting for a clock edge.
        issue(1'b0, LS_W, 32'h300, 32'h0);
        check("rstreq_mem_req_before", {31'd0, bus.mem_req}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rstreq_mem_req_async", {31'd0, bus.mem_req}, 32'd0);
        check("rstreq_busy_async", {31'd0, bus.busy}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("rstreq_ready_after", {31'd0, bus.req_ready}, 32'd1);

        // Reset in WAIT, then a stray rvalid while idle must not produce a response.
        issue(1'b0, LS_W, 32'h304, 32'h0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check("rstwait_busy_before", {31'd0, bus.busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rstwait_busy_async", {31'd0, bus.busy}, 32'd0);
        check("rstwait_mem_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        reset = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        bus.mem_rdata  = 32'h5A5A_5A5A;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;
        check("rstwait_ready_after", {31'd0, bus.req_ready}, 32'd1);
        step();
        load_fast("lw_after_rst", LS_W, 32'h308, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
        // TIMEOUT_CYCLES=4: mem_req high for cycles 1-4, timeout response at cycle 5.
        expect_resp(32'h0, ERR_TIMEOUT);
        issue(1'b0, LS_W, 32'h400, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req_held", {31'd0, bus.mem_req}, 32'd1);
            step();
        end
        check("to_mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
        check("to_resp_cycle", {31'd0, bus.resp_valid}, 32'd1);
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        step();
`else
        // Without the timeout the request is held as long as gnt stays low.
        expect_resp(32'h1122_3344, ERR_NONE);
        issue(1'b0, LS_W, 32'h400, 32'h0);
        for (int i = 0; i < 12; i++) begin
            check("nto_mem_req_held", {31'd0, bus.mem_req}, 32'd1);
            step();
        end
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("nto_resp_cycle", {31'd0, bus.resp_valid}, 32'd1);
        step();
`endif

        repeat (3) step();
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
